id_ex_pipe_reg: RTL and testbench

- Pipeline register between the instruction-decode stage (register-file read) and the execute stage of the 5-stage MIPS pipeline.
- Each cycle it captures decode-stage operands, immediate, register indices and control bits.
- Contains the load-use hazard detector: it inserts a bubble into EX and tells IF/ID to hold.
- Accepts a branch flush that kills the instruction currently in ID.

---
 rtl/id_ex_pipe_reg_if.sv | 58 +++++
 rtl/id_ex_pipe_reg.sv | 116 +++++++++++
 tb/tb_id_ex_pipe_reg.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: decode-stage inputs and execute-stage outputs.
// outBubbleCount exists only when ID_EX_BUBBLE_COUNT_EN is defined.
interface id_ex_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              inIdExValid;
    logic              inIdExFlush;
    logic [DATA_W-1:0] inIdExPcPlus4;
    logic [DATA_W-1:0] inIdExRsData;
    logic [DATA_W-1:0] inIdExRtData;
    logic [DATA_W-1:0] inIdExImm;
    logic [REG_AW-1:0] inIdExRs;
    logic [REG_AW-1:0] inIdExRt;
    logic [REG_AW-1:0] inIdExRd;
    logic [8:0]        inIdExCtrl;

    logic              outIdExValid;
    logic [DATA_W-1:0] outIdExPcPlus4;
    logic [DATA_W-1:0] outIdExRsData;
    logic [DATA_W-1:0] outIdExRtData;
    logic [DATA_W-1:0] outIdExImm;
    logic [REG_AW-1:0] outIdExRs;
    logic [REG_AW-1:0] outIdExRt;
    logic [REG_AW-1:0] outIdExRd;
    logic [8:0]        outIdExCtrl;
    logic              outStall;
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [CNT_W-1:0]  outBubbleCount;
`endif

    modport master (
        output inIdExValid, inIdExFlush, inIdExPcPlus4,
        output inIdExRsData, inIdExRtData, inIdExImm,
        output inIdExRs, inIdExRt, inIdExRd, inIdExCtrl,
        input  outIdExValid, outIdExPcPlus4,
        input  outIdExRsData, outIdExRtData, outIdExImm,
        input  outIdExRs, outIdExRt, outIdExRd,
        input  outIdExCtrl, outStall
`ifdef ID_EX_BUBBLE_COUNT_EN
        , input outBubbleCount
`endif
    );

    modport slave (
        input  inIdExValid, inIdExFlush, inIdExPcPlus4,
        input  inIdExRsData, inIdExRtData, inIdExImm,
        input  inIdExRs, inIdExRt, inIdExRd, inIdExCtrl,
        output outIdExValid, outIdExPcPlus4,
        output outIdExRsData, outIdExRtData, outIdExImm,
        output outIdExRs, outIdExRt, outIdExRd,
        output outIdExCtrl, outStall
`ifdef ID_EX_BUBBLE_COUNT_EN
        , output outBubbleCount
`endif
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard bubble and branch flush.
// Optional saturating hazard-bubble counter: ID_EX_BUBBLE_COUNT_EN.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic reset,
    id_ex_pipe_reg_if.slave bus
);
    localparam int MEMREAD = 6;

    logic              valid_q, valid_d;
    logic [8:0]        ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0] rsd_q,   rsd_d;
    logic [DATA_W-1:0] rtd_q,   rtd_d;
    logic [DATA_W-1:0] imm_q,   imm_d;
    logic [REG_AW-1:0] rs_q,    rs_d;
    logic [REG_AW-1:0] rt_q,    rt_d;
    logic [REG_AW-1:0] rd_q,    rd_d;
    logic              hz;

    // Rt compare is deliberately conservative for all instruction types
    assign hz = valid_q & ctrl_q[MEMREAD] & bus.inIdExValid
              & (rt_q != '0)
              & ((rt_q == bus.inIdExRs) | (rt_q == bus.inIdExRt));

    assign bus.outStall = hz & ~bus.inIdExFlush & ~reset;

    always_comb begin
        valid_d = bus.inIdExValid;
        ctrl_d  = bus.inIdExValid ? bus.inIdExCtrl : '0;
        pc_d    = bus.inIdExPcPlus4;
        rsd_d   = bus.inIdExRsData;
        rtd_d   = bus.inIdExRtData;
        imm_d   = bus.inIdExImm;
        rs_d    = bus.inIdExRs;
        rt_d    = bus.inIdExRt;
        rd_d    = bus.inIdExRd;
        if (bus.inIdExFlush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            pc_d    = '0;
            rsd_d   = '0;
            rtd_d   = '0;
            imm_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
        end else if (hz) begin
            // bubble keeps the old payload, only valid/ctrl are killed
            valid_d = 1'b0;
            ctrl_d  = '0;
            pc_d    = pc_q;
            rsd_d   = rsd_q;
            rtd_d   = rtd_q;
            imm_d   = imm_q;
            rs_d    = rs_q;
            rt_d    = rt_q;
            rd_d    = rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            rsd_q   <= '0;
            rtd_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            rsd_q   <= rsd_d;
            rtd_q   <= rtd_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

    assign bus.outIdExValid   = valid_q;
    assign bus.outIdExCtrl    = ctrl_q;
    assign bus.outIdExPcPlus4 = pc_q;
    assign bus.outIdExRsData  = rsd_q;
    assign bus.outIdExRtData  = rtd_q;
    assign bus.outIdExImm     = imm_q;
    assign bus.outIdExRs      = rs_q;
    assign bus.outIdExRt      = rt_q;
    assign bus.outIdExRd      = rd_q;

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hz && !bus.inIdExFlush && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus.outBubbleCount = cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg.
// Counter checks compile in only with ID_EX_BUBBLE_COUNT_EN.
module tb_id_ex_pipe_reg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 2;

    localparam logic [8:0] C_ADD = 9'h106;
    localparam logic [8:0] C_LW  = 9'h1C8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    id_ex_pipe_reg_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();

    id_ex_pipe_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [8:0] ctrl);
        bus.inIdExValid   = v;
        bus.inIdExRs      = rs;
        bus.inIdExRt      = rt;
        bus.inIdExRd      = rd;
        bus.inIdExRsData  = rsd;
        bus.inIdExRtData  = rtd;
        bus.inIdExImm     = imm;
        bus.inIdExPcPlus4 = pc;
        bus.inIdExCtrl    = ctrl;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.inIdExFlush = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 9'h0);
        tick();
        tick();
        check("rst_valid", 64'(bus.outIdExValid), 64'd0);
        check("rst_ctrl",  64'(bus.outIdExCtrl), 64'd0);
        check("rst_rsd",   64'(bus.outIdExRsData), 64'd0);
        check("rst_stall", 64'(bus.outStall), 64'd0);
        reset = 1'b0;

        // plain ADD
        drive(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 32'h104, C_ADD);
        check("add_stall", 64'(bus.outStall), 64'd0);
        tick();
        check("add_valid", 64'(bus.outIdExValid), 64'd1);
        check("add_rsd",   64'(bus.outIdExRsData), 64'h11);
        check("add_rtd",   64'(bus.outIdExRtData), 64'h22);
        check("add_rd",    64'(bus.outIdExRd), 64'd3);
        check("add_pc",    64'(bus.outIdExPcPlus4), 64'h104);
        check("add_ctrl",  64'(bus.outIdExCtrl), 64'(C_ADD));

        // LW r5 then dependent ADD
        drive(1'b1, 5'd1, 5'd5, 5'd0, 32'h33, 32'h44, 32'h4, 32'h108, C_LW);
        check("lw_stall", 64'(bus.outStall), 64'd0);
        tick();
        check("lw_ctrl", 64'(bus.outIdExCtrl), 64'(C_LW));
        drive(1'b1, 5'd5, 5'd2, 5'd7, 32'h55, 32'h22, 32'h0, 32'h10C, C_ADD);
        check("hz_stall", 64'(bus.outStall), 64'd1);
        tick();
        check("bub_valid", 64'(bus.outIdExValid), 64'd0);
        check("bub_ctrl",  64'(bus.outIdExCtrl), 64'd0);
        check("bub_rsd",   64'(bus.outIdExRsData), 64'h33);
        check("bub_rt",    64'(bus.outIdExRt), 64'd5);
        check("bub_pc",    64'(bus.outIdExPcPlus4), 64'h108);
        check("bub_stall", 64'(bus.outStall), 64'd0);
        tick();
        check("held_valid", 64'(bus.outIdExValid), 64'd1);
        check("held_rd",    64'(bus.outIdExRd), 64'd7);
        check("held_rsd",   64'(bus.outIdExRsData), 64'h55);
`ifdef ID_EX_BUBBLE_COUNT_EN
        check("cnt_1", 64'(bus.outBubbleCount), 64'd1);
`endif

        // LW writing r0 never hazards
        drive(1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 32'h110, C_LW);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 32'h114, C_ADD);
        check("r0_stall", 64'(bus.outStall), 64'd0);
        tick();
        check("r0_valid", 64'(bus.outIdExValid), 64'd1);
        check("r0_rd",    64'(bus.outIdExRd), 64'd9);

        // flush beats hazard
        drive(1'b1, 5'd1, 5'd5, 5'd0, 32'h1, 32'h2, 32'h4, 32'h118, C_LW);
        tick();
        bus.inIdExFlush = 1'b1;
        drive(1'b1, 5'd5, 5'd2, 5'd7, 32'h55, 32'h22, 32'h9, 32'h11C, C_ADD);
        check("fl_stall", 64'(bus.outStall), 64'd0);
        tick();
        bus.inIdExFlush = 1'b0;
        check("fl_valid", 64'(bus.outIdExValid), 64'd0);
        check("fl_ctrl",  64'(bus.outIdExCtrl), 64'd0);
        check("fl_rsd",   64'(bus.outIdExRsData), 64'd0);
        check("fl_rt",    64'(bus.outIdExRt), 64'd0);
        check("fl_imm",   64'(bus.outIdExImm), 64'd0);
        check("fl_pc",    64'(bus.outIdExPcPlus4), 64'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
        check("cnt_fl", 64'(bus.outBubbleCount), 64'd1);
`endif

        // LW r4; LW r6 using r4; ADD using r6
        drive(1'b1, 5'd1, 5'd4, 5'd0, 32'h0, 32'h0, 32'h0, 32'h120, C_LW);
        check("b2b_s0", 64'(bus.outStall), 64'd0);
        tick();
        drive(1'b1, 5'd4, 5'd6, 5'd0, 32'h0, 32'h0, 32'h0, 32'h124, C_LW);
        check("b2b_s1", 64'(bus.outStall), 64'd1);
        tick();
        check("b2b_s1b", 64'(bus.outStall), 64'd0);
        tick();
        check("b2b_lw2", 64'(bus.outIdExRt), 64'd6);
        drive(1'b1, 5'd6, 5'd2, 5'd8, 32'h0, 32'h0, 32'h0, 32'h128, C_ADD);
        check("b2b_s2", 64'(bus.outStall), 64'd1);
        tick();
        check("b2b_bub", 64'(bus.outIdExValid), 64'd0);
        tick();
        check("b2b_add", 64'(bus.outIdExRd), 64'd8);
        check("b2b_val", 64'(bus.outIdExValid), 64'd1);
`ifdef ID_EX_BUBBLE_COUNT_EN
        check("cnt_3", 64'(bus.outBubbleCount), 64'd3);
`endif

        // another hazard: counter must saturate
        drive(1'b1, 5'd1, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 32'h12C, C_LW);
        tick();
        drive(1'b1, 5'd2, 5'd5, 5'd3, 32'h0, 32'h0, 32'h0, 32'h130, C_ADD);
        check("sat_stall", 64'(bus.outStall), 64'd1);
        tick();
`ifdef ID_EX_BUBBLE_COUNT_EN
        check("cnt_sat", 64'(bus.outBubbleCount), 64'd3);
`endif
        tick();

        // invalid ID slot never stalls, gives Ctrl=0
        drive(1'b1, 5'd1, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 32'h134, C_LW);
        tick();
        drive(1'b0, 5'd5, 5'd5, 5'd3, 32'h0, 32'h0, 32'h0, 32'h138, C_ADD);
        check("inv_stall", 64'(bus.outStall), 64'd0);
        tick();
        check("inv_valid", 64'(bus.outIdExValid), 64'd0);
        check("inv_ctrl",  64'(bus.outIdExCtrl), 64'd0);
        check("inv_pc",    64'(bus.outIdExPcPlus4), 64'h138);

        // reset mid-stall
        drive(1'b1, 5'd1, 5'd5, 5'd0, 32'hAA, 32'h0, 32'h0, 32'h13C, C_LW);
        tick();
        drive(1'b1, 5'd5, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 32'h140, C_ADD);
        check("pre_rst_stall", 64'(bus.outStall), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_stall_drop", 64'(bus.outStall), 64'd0);
        tick();
        check("rst2_valid", 64'(bus.outIdExValid), 64'd0);
        check("rst2_ctrl",  64'(bus.outIdExCtrl), 64'd0);
        check("rst2_rsd",   64'(bus.outIdExRsData), 64'd0);
        check("rst2_rt",    64'(bus.outIdExRt), 64'd0);
        check("rst2_pc",    64'(bus.outIdExPcPlus4), 64'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
        check("cnt_rst", 64'(bus.outBubbleCount), 64'd0);
`endif
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
